// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: default widths,
// source indices and the round-robin pointer advance.
package cdb_arbiter_pkg;

  localparam int CDB_N_REQ  = 3;
  localparam int CDB_TAG_W  = 4;
  localparam int CDB_DATA_W = 32;

  // Fixed requester slots on the CDB.
  typedef enum logic [1:0] {
    CDB_ALU = 2'd0,
    CDB_LSB = 2'd1,
    CDB_AUX = 2'd2
  } cdb_src_e;

  // Index following idx in a ring of n slots.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set request
// found scanning upward from ptr with wrap. Reused for the LSB memory port.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Rotating priority scan; a disabled arbiter grants nothing.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among result producers and a
// registered one-cycle broadcast of the winner's tag and data.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = CDB_N_REQ,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W,
  parameter int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [SRC_W-1:0]        cdb_src
);

  logic [SRC_W-1:0]  rr_ptr;
  logic [N_REQ-1:0]  gnt;
  logic              grant_en;
  logic [SRC_W-1:0]  win_idx;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  // Grant only when out of reset, enabled and not flushing.
  assign grant_en = rst && rdy && !flush;

  rr_arbiter #(.N(N_REQ), .PW(SRC_W)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  (grant_en),
    .gnt (gnt)
  );

  assign req_ready = gnt;

  // Select the granted requester's index, tag and data.
  always_comb begin
    win_idx  = '0;
    win_tag  = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_idx  = SRC_W'(i);
        win_tag  = req_tag[i*TAG_W +: TAG_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Broadcast register and pointer; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (rdy) begin
      if (|gnt) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= win_tag;
        cdb_data  <= win_data;
        cdb_src   <= win_idx;
        rr_ptr    <= SRC_W'(rr_next(32'(win_idx), N_REQ));
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, round-robin order, idle hold,
// flush, rdy stall, wrap-around and asynchronous reset mid-broadcast.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TW = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          rdy;
  logic          flush;
  logic [N-1:0]  req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [1:0]    cdb_src;

  int total;
  int bad;

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_tag[i*TW +: TW]  = t;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 3'b111;
    set_req(0, 4'd5, 32'd100);
    set_req(1, 4'd6, 32'd101);
    set_req(2, 4'd7, 32'd102);
    tick();
    tick();
    total++;
    if (req_ready !== 3'b000) begin
      bad++;
      $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    total++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0 || cdb_data !== 32'd0 || cdb_src !== 2'd0) begin
      bad++;
      $display("FAIL reset_regs: got v=%b t=%0d d=%h s=%0d want 0/0/0/0",
               cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    rst = 1'b1;
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++;
      $display("FAIL reset_first_grant: got %b want 001", req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    for (int k = 0; k < 6; k++) begin
      exp_g = 3'b001 << (k % 3);
      total++;
      if (req_ready !== exp_g) begin
        bad++;
        $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_g);
      end
      tick();
      total++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 4'(5 + k % 3) || cdb_src !== 2'(k % 3)
          || cdb_data !== 32'(100 + k % 3)) begin
        bad++;
        $display("FAIL rr_bcast[%0d]: got v=%b t=%0d s=%0d d=%0d want 1/%0d/%0d/%0d",
                 k, cdb_valid, cdb_tag, cdb_src, cdb_data, 5 + k % 3, k % 3, 100 + k % 3);
      end
    end
  endtask

  // rr_ptr is 0 on entry.
  task automatic test_single_idle();
    req_valid = 3'b010;
    set_req(1, 4'd3, 32'hDEADBEEF);
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++;
      $display("FAIL single_grant: got %b want 010", req_ready);
    end
    tick();
    req_valid = 3'b000;
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd3 || cdb_data !== 32'hDEADBEEF || cdb_src !== 2'd1) begin
      bad++;
      $display("FAIL single_bcast: got v=%b t=%0d d=%h s=%0d want 1/3/deadbeef/1",
               cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    #1;
    total++;
    if (req_ready !== 3'b000) begin
      bad++;
      $display("FAIL idle_grant: got %b want 000", req_ready);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 4'd3 || cdb_data !== 32'hDEADBEEF || cdb_src !== 2'd1) begin
      bad++;
      $display("FAIL idle_hold: got v=%b t=%0d d=%h s=%0d want 0/3/deadbeef/1",
               cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
  endtask

  // rr_ptr is 2 on entry.
  task automatic test_flush();
    set_req(0, 4'd1, 32'h11);
    set_req(1, 4'd2, 32'h22);
    set_req(2, 4'd4, 32'h44);
    req_valid = 3'b011;
    flush = 1'b1;
    #1;
    total++;
    if (req_ready !== 3'b000) begin
      bad++;
      $display("FAIL flush_grant: got %b want 000", req_ready);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_valid: got %b want 0", cdb_valid);
    end
    flush = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++;
      $display("FAIL flush_release_grant: got %b want 001", req_ready);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 4'd1) begin
      bad++;
      $display("FAIL flush_release_bcast: got v=%b s=%0d t=%0d want 1/0/1", cdb_valid, cdb_src, cdb_tag);
    end
    // rr_ptr now 1; a second flush must leave it there.
    req_valid = 3'b101;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b100) begin
      bad++;
      $display("FAIL flush_ptr_hold: got %b want 100", req_ready);
    end
    tick();
    req_valid = 3'b000;
    total++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_tag !== 4'd4 || cdb_data !== 32'h44) begin
      bad++;
      $display("FAIL flush_ptr_bcast: got v=%b s=%0d t=%0d d=%h want 1/2/4/44",
               cdb_valid, cdb_src, cdb_tag, cdb_data);
    end
    tick();
  endtask

  // rr_ptr is 0 on entry.
  task automatic test_stall();
    set_req(0, 4'd9, 32'h99);
    set_req(1, 4'd10, 32'hAA);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b010;
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (req_ready !== 3'b000) begin
        bad++;
        $display("FAIL stall_grant[%0d]: got %b want 000", c, req_ready);
      end
      tick();
      total++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 4'd9 || cdb_src !== 2'd0 || cdb_data !== 32'h99) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got v=%b t=%0d s=%0d d=%h want 1/9/0/99",
                 c, cdb_valid, cdb_tag, cdb_src, cdb_data);
      end
    end
    rdy = 1'b1;
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++;
      $display("FAIL stall_resume_grant: got %b want 010", req_ready);
    end
    tick();
    req_valid = 3'b000;
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd10 || cdb_src !== 2'd1) begin
      bad++;
      $display("FAIL stall_resume_bcast: got v=%b t=%0d s=%0d want 1/10/1", cdb_valid, cdb_tag, cdb_src);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_dup: got %b want 0", cdb_valid);
    end
  endtask

  // rr_ptr is 2 on entry.
  task automatic test_wrap();
    logic [N-1:0] exp_g [3];
    logic [N-1:0] vin   [3];
    exp_g = '{3'b001, 3'b100, 3'b001};
    vin   = '{3'b001, 3'b101, 3'b101};
    set_req(0, 4'd1, 32'h1);
    set_req(2, 4'd2, 32'h2);
    for (int k = 0; k < 3; k++) begin
      req_valid = vin[k];
      #1;
      total++;
      if (req_ready !== exp_g[k]) begin
        bad++;
        $display("FAIL wrap_grant[%0d]: got %b want %b", k, req_ready, exp_g[k]);
      end
      tick();
      total++;
      if (cdb_valid !== 1'b1 || cdb_src !== ((k == 1) ? 2'd2 : 2'd0)) begin
        bad++;
        $display("FAIL wrap_src[%0d]: got v=%b s=%0d", k, cdb_valid, cdb_src);
      end
    end
  endtask

  task automatic test_async_reset();
    req_valid = 3'b111;
    tick();
    req_valid = 3'b000;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0 || cdb_src !== 2'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%b t=%0d s=%0d want 0/0/0", cdb_valid, cdb_tag, cdb_src);
    end
    total++;
    if (req_ready !== 3'b000) begin
      bad++;
      $display("FAIL async_reset_ready: got %b want 000", req_ready);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    rdy = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_tag = '0;
    req_data = '0;
    test_reset();
    test_round_robin();
    test_single_idle();
    test_flush();
    test_stall();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. It shares the single result broadcast bus (CDB) between the execution-side producers: ALU results from the reservation station, load results from the load/store buffer, and any further writeback source. It grants one requester per cycle using a round-robin policy and registers the winner onto the CDB. The ROB, RS, LSB and register file then capture results by ROB tag.

## Interface
Parameters:
- N_REQ, 3, number of requesters; index 0 = ALU/RS, 1 = LSB load, 2 = spare writeback source
- TAG_W, 4, ROB tag width; matches `ROBRange`
- DATA_W, 32, result width

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- rdy  input  1  global enable; low freezes all state
- flush  input  1  misprediction clear from ROB
- req_valid  input  N_REQ  requester i holds a result
- req_tag  input  N_REQ*TAG_W  ROB tag of requester i, slice [i*TAG_W +: TAG_W]
- req_data  input  N_REQ*DATA_W  result of requester i, slice [i*DATA_W +: DATA_W]
- req_ready  output  N_REQ  one-hot grant, combinational
- cdb_valid  output  1  broadcast valid
- cdb_tag  output  TAG_W  broadcast ROB tag
- cdb_data  output  DATA_W  broadcast value
- cdb_src  output  $clog2(N_REQ)  index of the source that produced the current broadcast

## Operation
- State:
  - rr_ptr, range 0..N_REQ-1: highest-priority index for the next grant.
  - Output registers: cdb_valid, cdb_tag, cdb_data, cdb_src.
- Grant, combinational. When rst is high, rdy is high and flush is low, scan indices rr_ptr, rr_ptr+1, … mod N_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1; all other bits are 0. If no requester is valid, req_ready = 0.
- Handshake: a transfer occurs on a cycle where req_valid[i] and req_ready[i] are both 1. The requester must hold valid, tag and data stable until that transfer. After the transfer it may drop valid or present a new result.
- On a transfer from i:
  - Next cycle: cdb_valid=1, cdb_tag=req_tag[i], cdb_data=req_data[i], cdb_src=i.
  - rr_ptr <= (i+1) mod N_REQ.
- No transfer, with rdy high and flush low: cdb_valid <= 0. cdb_tag, cdb_data and cdb_src hold. rr_ptr holds.
- The CDB has no backpressure. Each broadcast lasts exactly one rdy-high cycle.
- flush high (with rdy high):
  - req_ready = 0.
  - cdb_valid <= 0.
  - rr_ptr holds.
  - Requester state is the requesters' own responsibility; they clear on flush.
- rdy low: req_ready = 0 and every register holds, including cdb_valid. Consumers are also rdy-gated, so no duplicate capture occurs.
- Fairness: a continuously valid requester is granted within N_REQ rdy-high, non-flush cycles.

## Timing
- Reset (rst=0, async): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0.
  - req_ready=0 while rst=0.
  - Deassertion takes effect at the next clock edge.
- Latency: one cycle from grant to broadcast. Peak throughput is one result per cycle.
- Simultaneous events:
  - flush with valid requests: flush wins and nothing is granted.
  - flush with rdy low: freeze wins.
- Wrap-around: a grant to index N_REQ-1 sets rr_ptr to 0.
- Single requester always valid: granted every cycle, rr_ptr cycles but the grant is unaffected.
- Reset mid-broadcast: cdb_valid drops immediately (async). The pending result is lost; the ROB is also reset.

## Structure
- TAG_W/DATA_W derive from `ROBRange` and the data width in `defines.v`.
- Shared constants: source indices `CDB_ALU`=0, `CDB_LSB`=1, `CDB_AUX`=2, also placed in `defines.v`.
- One sub-module is natural: `rr_arbiter` (parameter N; inputs req, ptr, en; output one-hot gnt). It is purely combinational and reusable for the LSB memory-port arbitration.
- cdb_arbiter owns the pointer and output registers.

## Test plan
- Reset: hold rst=0 with req_valid=3'b111 -> req_ready=0, cdb_valid=0. Release rst -> first grant goes to index 0 (rr_ptr=0).
- Round-robin: req_valid=3'b111 held, tags 5/6/7 -> cdb_tag sequence 5,6,7,5,6,7 on consecutive cycles, cdb_src 0,1,2,…, cdb_valid continuously 1.
- Single source plus idle: only req 1 valid for one cycle (tag 3, data 0xDEADBEEF) -> next cycle cdb_valid=1, tag=3, data=0xDEADBEEF, src=1. The following cycle cdb_valid=0 while tag and data hold.
- Flush: req_valid=3'b011 with flush=1 -> req_ready=0, next cycle cdb_valid=0, rr_ptr unchanged. Release flush -> grant follows the pre-flush rr_ptr.
- rdy stall: broadcast tag 9 in flight, rdy=0 for 3 cycles -> cdb_valid=1, tag=9 hold and req_ready=0. rdy=1 -> normal progression with no duplicated grant.
- Wrap and fairness: rr_ptr=2, req_valid=3'b001 then 3'b101 -> grant 0, then 2, then 0. Any continuously valid request is served within 3 cycles.
